module_als_spi_reader: RTL

SPI master for the PMOD ALS ambient-light sensor (ADC081S021, 8-bit). Periodically runs one 16-clock conversion frame and extracts the 8-bit light sample. Publishes the sample with a one-cycle valid strobe. Sits directly upstream of the binary-to-BCD conversion stage, which consumes `DATO` on `DATO_VALID`.

---
 rtl/als_pkg.sv | 18 +
 rtl/module_sync_2ff.sv | 21 ++
 rtl/module_als_spi_reader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/als_pkg.sv
// Shared types and frame constants for the PMOD ALS (ADC081S021) SPI reader.
package als_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} als_state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_MSB   = 12;
    localparam int DATA_LSB   = 5;
    localparam int DATA_W     = 8;

    // Observation bundle: FSM state, bit counter and raw shift register.
    typedef struct packed {
        als_state_t              state;
        logic [4:0]              bit_cnt;
        logic [FRAME_BITS-1:0]   shift;
    } als_dbg_t;

endpackage

// File: rtl/module_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module module_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/module_als_spi_reader.sv
// SPI master that periodically reads one 16-clock frame from the ALS ADC
// and publishes the 8-bit light sample with a one-cycle valid strobe.
module module_als_spi_reader
    import als_pkg::*;
#(
    parameter int CLK_DIV       = 13,
    parameter int SAMPLE_PERIOD = 10_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EN,
    input  logic              MISO,
    output logic              CS_N,
    output logic              SCLK,
    output logic [DATA_W-1:0] DATO,
    output logic              DATO_VALID,
    output als_dbg_t          dbg
);

    localparam int SP_W = $clog2(SAMPLE_PERIOD);
    localparam int CD_W = $clog2(CLK_DIV);
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(SAMPLE_PERIOD - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(CLK_DIV - 1);

    als_state_t            state;
    logic [SP_W-1:0]       icnt;
    logic [CD_W-1:0]       pcnt;
    logic [4:0]            bcnt;
    logic [FRAME_BITS-1:0] shift;
    logic [FRAME_BITS-1:0] shift_nxt;
    logic                  miso_s;
    logic                  tick;

    module_sync_2ff u_sync_miso (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (MISO),
        .q     (miso_s)
    );

    // Free-running interval counter; keeps counting while disabled so that
    // frame starts stay on a fixed grid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            icnt <= '0;
        else if (icnt == SP_LAST)
            icnt <= '0;
        else
            icnt <= icnt + 1'b1;
    end

    assign tick      = (icnt == SP_LAST);
    assign shift_nxt = {shift[FRAME_BITS-2:0], miso_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pcnt       <= '0;
            bcnt       <= '0;
            shift      <= '0;
            CS_N       <= 1'b1;
            SCLK       <= 1'b1;
            DATO       <= '0;
            DATO_VALID <= 1'b0;
        end else begin
            DATO_VALID <= 1'b0;
            case (state)
                IDLE: begin
                    CS_N <= 1'b1;
                    SCLK <= 1'b1;
                    pcnt <= '0;
                    bcnt <= '0;
                    if (tick && EN) begin
                        state <= SETUP;
                        CS_N  <= 1'b0;
                    end
                end
                SETUP: begin
                    if (pcnt == CD_LAST) begin
                        pcnt  <= '0;
                        SCLK  <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (pcnt == CD_LAST) begin
                        pcnt <= '0;
                        if (!SCLK) begin
                            SCLK <= 1'b1;
                        end else begin
                            // End of a high phase: data has settled since the falling edge.
                            shift <= shift_nxt;
                            bcnt  <= bcnt + 5'd1;
                            if (bcnt == 5'd15) begin
                                state      <= DONE;
                                CS_N       <= 1'b1;
                                DATO       <= shift_nxt[DATA_MSB:DATA_LSB];
                                DATO_VALID <= 1'b1;
                            end else begin
                                SCLK <= 1'b0;
                            end
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg = '{state: state, bit_cnt: bcnt, shift: shift};

endmodule
